// File: rtl/hash_dispatch.sv
// hash_dispatch: initiator for one hashing module. Walks the nonce space in
// steps of NONCE_STEP starting at NONCE_START, launches one job per nonce,
// and reports a found hash, nonce-space exhaustion or a job timeout.
module hash_dispatch #(
   parameter logic [31:0] NONCE_START    = 32'h0,
   parameter logic [31:0] NONCE_STEP     = 32'h1,
   parameter int          TIMEOUT_CYCLES = 400
) (
   input  logic         clk,
   input  logic         n_rst,
   input  logic         start,
   input  logic         stop,
   input  logic [479:0] template,
   input  logic [255:0] target,
   input  logic         hash_done,
   input  logic         valid_hash_flag,
   input  logic [255:0] valid_hash,
   output logic         begin_hash,
   output logic         quit_hash,
   output logic [511:0] data_to_hash,
   output logic [255:0] difficulty,
   output logic         busy,
   output logic         found,
   output logic         exhausted,
   output logic         timeout_err,
   output logic [31:0]  found_nonce,
   output logic [255:0] found_hash,
   output logic [31:0]  hash_count
);

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_LAUNCH    = 3'd1;
   localparam logic [2:0] ST_WAIT      = 3'd2;
   localparam logic [2:0] ST_FOUND     = 3'd3;
   localparam logic [2:0] ST_EXHAUSTED = 3'd4;
   localparam logic [2:0] ST_TIMEOUT   = 3'd5;
   localparam logic [2:0] ST_ABORT     = 3'd6;

   localparam logic [15:0] WAIT_LIMIT = 16'(TIMEOUT_CYCLES - 1);

   logic [2:0]   state;
   logic [2:0]   next_state;
   logic [31:0]  nonce;
   logic [479:0] template_q;
   logic [15:0]  wait_cnt;
   logic         done_armed;
   logic         stop_pend;
   logic         abort_to;

   logic [32:0]  nonce_sum;
   logic         stop_eff;
   logic         start_ok;
   logic         ev_found;
   logic         ev_invalid;
   logic         ev_timeout;

   // Next-state decode and the per-cycle job events; stop beats any result,
   // and a hash_done is only honoured once it has been seen low this job.
   always_comb begin
      nonce_sum  = {1'b0, nonce} + {1'b0, NONCE_STEP};
      stop_eff   = stop | stop_pend;
      start_ok   = 1'b0;
      ev_found   = 1'b0;
      ev_invalid = 1'b0;
      ev_timeout = 1'b0;
      next_state = state;
      case (state)
         ST_IDLE, ST_FOUND, ST_EXHAUSTED, ST_TIMEOUT: begin
            if (start) begin
               start_ok   = 1'b1;
               next_state = ST_LAUNCH;
            end
         end
         ST_LAUNCH: begin
            next_state = ST_WAIT;
         end
         ST_WAIT: begin
            if (stop_eff) begin
               next_state = ST_ABORT;
            end else if (done_armed && hash_done && valid_hash_flag) begin
               ev_found   = 1'b1;
               next_state = ST_FOUND;
            end else if (done_armed && hash_done) begin
               ev_invalid = 1'b1;
               next_state = nonce_sum[32] ? ST_EXHAUSTED : ST_LAUNCH;
            end else if (wait_cnt == WAIT_LIMIT) begin
               ev_timeout = 1'b1;
               next_state = ST_ABORT;
            end
         end
         ST_ABORT: begin
            next_state = abort_to ? ST_TIMEOUT : ST_IDLE;
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
   end

   // Sequencing state: FSM, nonce walk, wait timer, done arming and stop capture.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state      <= ST_IDLE;
         nonce      <= NONCE_START;
         wait_cnt   <= 16'd0;
         done_armed <= 1'b0;
         stop_pend  <= 1'b0;
         abort_to   <= 1'b0;
      end else begin
         state     <= next_state;
         stop_pend <= (state == ST_LAUNCH) && stop;
         if (start_ok) begin
            nonce <= NONCE_START;
         end else if (ev_invalid && !nonce_sum[32]) begin
            nonce <= nonce_sum[31:0];
         end
         if (state == ST_LAUNCH) begin
            wait_cnt   <= 16'd0;
            done_armed <= 1'b0;
         end else if (state == ST_WAIT) begin
            wait_cnt <= wait_cnt + 16'd1;
            if (!hash_done) begin
               done_armed <= 1'b1;
            end
         end
         if (state == ST_WAIT) begin
            abort_to <= ev_timeout;
         end
      end
   end

   // Job parameters are captured only when a new mining run is accepted.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         template_q <= '0;
         difficulty <= '0;
      end else if (start_ok) begin
         template_q <= template;
         difficulty <= target;
      end
   end

   // Handshake to the hashing module; the job word is loaded alongside begin_hash
   // and then held untouched until the following launch.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         begin_hash   <= 1'b0;
         quit_hash    <= 1'b0;
         data_to_hash <= '0;
      end else begin
         begin_hash <= (state == ST_LAUNCH);
         quit_hash  <= (next_state == ST_ABORT);
         if (state == ST_LAUNCH) begin
            data_to_hash <= {template_q, nonce};
         end
      end
   end

   // Status toward the mining top level, registered from the upcoming state.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         busy        <= 1'b0;
         found       <= 1'b0;
         exhausted   <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         busy        <= (next_state == ST_LAUNCH) || (next_state == ST_WAIT) ||
                        (next_state == ST_ABORT);
         found       <= (next_state == ST_FOUND);
         exhausted   <= (next_state == ST_EXHAUSTED);
         timeout_err <= (next_state == ST_TIMEOUT);
      end
   end

   // Result capture and the saturating completed-job counter.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         found_nonce <= 32'd0;
         found_hash  <= '0;
         hash_count  <= 32'd0;
      end else begin
         if (ev_found) begin
            found_nonce <= nonce;
            found_hash  <= valid_hash;
         end
         if (start_ok) begin
            hash_count <= 32'd0;
         end else if ((ev_found || ev_invalid) && (hash_count != 32'hFFFF_FFFF)) begin
            hash_count <= hash_count + 32'd1;
         end
      end
   end

endmodule

// File: doc/hash_dispatch.md
Name: hash_dispatch

Overview:
- Initiator side of the hashing-module job interface: owns nonce sequencing and the begin_hash/quit_hash handshake into one hashing module.
- Also drives the module's difficulty and data_to_hash inputs, and collects its hash_done/valid_hash_flag/valid_hash results.
- One instance sits in front of each hashing-module instance; NONCE_STEP/NONCE_START interleave the nonce space across instances.
- Reports found nonce/hash, exhaustion or timeout to the mining top level.

Parameters:
NONCE_START, 32'h0, first nonce issued after start.
NONCE_STEP, 32'h1, nonce increment per job (set to number of hashing modules).
TIMEOUT_CYCLES, 400, max cycles waiting for hash_done before abort (16-bit counter).

Ports:
clk  in  1  system clock, rising edge.
n_rst  in  1  asynchronous active-low reset.
start  in  1  one-cycle pulse; latch job and begin mining (ignored unless IDLE/FOUND/EXHAUSTED/TIMEOUT).
stop  in  1  abort current job (e.g. another module found a hash).
template  in  480  header words excluding nonce; latched on start.
target  in  256  difficulty; latched on start.
hash_done  in  1  from hashing module.
valid_hash_flag  in  1  from hashing module, qualified by hash_done.
valid_hash  in  256  from hashing module, qualified by hash_done.
begin_hash  out  1  one-cycle launch pulse.
quit_hash  out  1  one-cycle abort pulse.
data_to_hash  out  512  {template_q, nonce}; nonce in bits [31:0].
difficulty  out  256  registered target.
busy  out  1  high in LAUNCH/WAIT/ABORT.
found  out  1  level, high in FOUND.
exhausted  out  1  level, high in EXHAUSTED.
timeout_err  out  1  level, high in TIMEOUT.
found_nonce  out  32  nonce of valid hash.
found_hash  out  256  latched valid_hash.
hash_count  out  32  jobs completed since start, saturating.

Behaviour:
- Reset (async, n_rst=0): state IDLE; every output 0; nonce=NONCE_START; wait counter 0.
- States: IDLE, LAUNCH, WAIT, FOUND, EXHAUSTED, TIMEOUT, ABORT. All outputs registered.
- IDLE/FOUND/EXHAUSTED/TIMEOUT:
  - start -> latch template/target, nonce=NONCE_START, hash_count=0, clear found/exhausted/timeout_err -> LAUNCH.
  - start during LAUNCH/WAIT/ABORT is ignored.
- LAUNCH:
  - begin_hash=1 for exactly this cycle; data_to_hash valid in the same cycle and held stable until the next LAUNCH.
  - Clear wait counter; clear done_armed -> WAIT.
- WAIT:
  - done_armed sets on the first cycle hash_done=0. Prevents a stale level-high hash_done from the previous job being counted.
  - Counter increments every cycle.
  - Priority, highest first:
    1. stop -> ABORT.
    2. done_armed && hash_done && valid_hash_flag -> latch found_hash=valid_hash, found_nonce=nonce; hash_count+1 -> FOUND.
    3. done_armed && hash_done, invalid:
       - hash_count+1.
       - If nonce+NONCE_STEP (33-bit) > 32'hFFFF_FFFF -> EXHAUSTED.
       - Else nonce+=NONCE_STEP -> LAUNCH.
    4. counter==TIMEOUT_CYCLES-1 -> ABORT, with timeout_err to be set.
- Latency: hash_done sampled at cycle N -> next begin_hash at N+2.
- ABORT:
  - quit_hash=1 for one cycle.
  - Next state TIMEOUT if entered via timeout, else IDLE.
  - Found results from an aborted job are discarded.
- stop outside WAIT: no effect, except stop in LAUNCH, which is held pending and taken on the first WAIT cycle.
- stop and valid hash_done in the same cycle: stop wins; no found.
- hash_count saturates at 32'hFFFF_FFFF.

Test Plan:
- Reset mid-WAIT (n_rst low 1 cycle) -> all outputs 0 immediately, state IDLE, begin_hash never pulses until next start.
- start, template=all 0xA5, NONCE_START=0, STEP=1; module returns invalid 3 times then valid hash 0x00..01 -> begin_hash pulses with nonce 0,1,2,3; found=1, found_nonce=3, found_hash=0x00..01, hash_count=4.
- NONCE_START=32'hFFFF_FFFD, STEP=2, always invalid -> jobs at nonces FFFF_FFFD, FFFF_FFFF, then exhausted=1, busy=0, no third begin_hash.
- hash_done held high across LAUNCH into WAIT, then low, then high -> only the second high is counted (hash_count=1).
- hash_done never asserts, TIMEOUT_CYCLES=400 -> quit_hash one-cycle pulse 400 cycles after entering WAIT, timeout_err=1; start then relaunches with nonce=NONCE_START.
- stop coincident with valid hash_done -> quit_hash pulse, found stays 0, state IDLE; start during WAIT ignored.
